// File: rtl/bcd_seg7_scan_driver.sv
// bcd_seg7_scan_driver
//   Time-multiplexes BCD_NUM BCD digits onto one shared 7-segment bus with one-hot digit enables.
//   Digits and decimal points are snapshotted once per frame, so a frame never mixes two counter
//   values. Each digit slot starts with BLANK_CYCLES clocks of all enables off (anti-ghosting).
//
//   Optional feature: define SEG7_LZ_BLANK_EN for leading-zero blanking. Digits above the most
//   significant nonzero digit are kept dark unless their decimal point is set. Digit 0 always shows.
//
// Ports
//   clk         clock, all state on rising edge
//   reset       asynchronous, active-low reset
//   bcds        BCD digits, bcds[0] is least significant
//   freeze      1 = keep the current snapshot at the frame boundary
//   dp_mask     decimal point per digit, sampled with the snapshot
//   seg         segments {g,f,e,d,c,b,a}, active-high
//   dp          decimal point of the enabled digit, active-high
//   an          one-hot digit enable, active-high, all-zero during the blank gap
//   frame_done  one-cycle pulse per completed frame
module bcd_seg7_scan_driver #(
  parameter int unsigned BCD_NUM      = 8,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         bcds [BCD_NUM-1:0],
  input  logic               freeze,
  input  logic [BCD_NUM-1:0] dp_mask,
  output logic [6:0]         seg,
  output logic               dp,
  output logic [BCD_NUM-1:0] an,
  output logic               frame_done
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned IW = (BCD_NUM > 1) ? $clog2(BCD_NUM) : 1;

  localparam logic [PW-1:0] PLast   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PBlank  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IdxLast = IW'(BCD_NUM - 1);

  logic [PW-1:0]      p_q;
  logic [IW-1:0]      idx_q;
  logic [3:0]         shadow_q [BCD_NUM-1:0];
  logic [BCD_NUM-1:0] dp_shadow_q;
  logic [6:0]         seg_q;
  logic               dp_q;
  logic [BCD_NUM-1:0] an_q;
  logic               frame_done_q;

  logic               slot_end;
  logic               frame_end;
  logic               snap;
  logic [6:0]         seg_d;
  logic               dp_d;
  logic [BCD_NUM-1:0] an_d;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40; // non-BCD code shows a dash
    endcase
    return s;
  endfunction

  assign slot_end  = (p_q == PLast);
  assign frame_end = slot_end && (idx_q == IdxLast);
  assign snap      = frame_end && !freeze;

`ifdef SEG7_LZ_BLANK_EN
  logic [IW-1:0] msd_q;
  logic [IW-1:0] msd_d;

  // Most significant nonzero digit of the incoming sample; 0 when all digits are zero.
  always_comb begin
    msd_d = '0;
    for (int i = 0; i < int'(BCD_NUM); i++) begin
      if (bcds[i] != 4'd0) msd_d = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msd_q <= '0;
    end else if (snap) begin
      msd_q <= msd_d;
    end
  end

  always_comb begin
    an_d  = '0;
    seg_d = 7'h00;
    dp_d  = 1'b0;
    if (p_q >= PBlank) begin
      if (idx_q <= msd_q) begin
        an_d[idx_q] = 1'b1;
        seg_d       = decode(shadow_q[idx_q]);
        dp_d        = dp_shadow_q[idx_q];
      end else if (dp_shadow_q[idx_q]) begin
        // Blanked leading zero still carries its decimal point.
        an_d[idx_q] = 1'b1;
        dp_d        = 1'b1;
      end
    end
  end
`else
  always_comb begin
    an_d  = '0;
    seg_d = 7'h00;
    dp_d  = 1'b0;
    if (p_q >= PBlank) begin
      an_d[idx_q] = 1'b1;
      seg_d       = decode(shadow_q[idx_q]);
      dp_d        = dp_shadow_q[idx_q];
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q          <= '0;
      idx_q        <= '0;
      dp_shadow_q  <= '0;
      seg_q        <= 7'h00;
      dp_q         <= 1'b0;
      an_q         <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < int'(BCD_NUM); i++) shadow_q[i] <= 4'd0;
    end else begin
      if (slot_end) begin
        p_q   <= '0;
        idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end else begin
        p_q <= p_q + 1'b1;
      end
      if (snap) begin
        dp_shadow_q <= dp_mask;
        for (int i = 0; i < int'(BCD_NUM); i++) shadow_q[i] <= bcds[i];
      end
      frame_done_q <= frame_end;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
